// File: rtl/dvsd_mul_acc.sv
// Multiply-accumulate stage: registered operand pair -> Dadda 8x8 multiplier -> ACC_W accumulator.
// Optional macro DVSD_MAC_SAT_EN: clamp the sum at 2^ACC_W-1 instead of wrapping.

module dvsd_8216m3 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   logic [15:0] pp [8];
   logic [15:0] l1 [6];
   logic [15:0] l2 [4];
   logic [15:0] l3 [3];
   logic [15:0] l4 [2];
   logic [31:0] t0, t1, t2, t3, t4, t5, t6;

   // Carry-save compressor on whole rows; returns {carry, sum}.
   function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
      logic [15:0] s;
      logic [15:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         pp[i] = b[i] ? (16'(a) << i) : 16'd0;
      end
      // Reduction heights 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
      t0 = csa(pp[0], pp[1], pp[2]);
      t1 = csa(pp[3], pp[4], pp[5]);
      l1[0] = t0[15:0];
      l1[1] = t0[31:16];
      l1[2] = t1[15:0];
      l1[3] = t1[31:16];
      l1[4] = pp[6];
      l1[5] = pp[7];
      t2 = csa(l1[0], l1[1], l1[2]);
      t3 = csa(l1[3], l1[4], l1[5]);
      l2[0] = t2[15:0];
      l2[1] = t2[31:16];
      l2[2] = t3[15:0];
      l2[3] = t3[31:16];
      t4 = csa(l2[0], l2[1], l2[2]);
      l3[0] = t4[15:0];
      l3[1] = t4[31:16];
      l3[2] = l2[3];
      t5 = csa(l3[0], l3[1], l3[2]);
      l4[0] = t5[15:0];
      l4[1] = t5[31:16];
      t6 = 32'd0;
      p = l4[0] + l4[1];
   end

endmodule

module dvsd_mul_acc #(
   parameter int LEN   = 4,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             ovf
);

   localparam int CNT_W = $clog2(LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       op_a_q, op_a_d, op_b_q, op_b_d;
   logic             op_v_q, op_v_d, op_last_q, op_last_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             in_acc, out_acc;
   logic [15:0]      product;
   logic [ACC_W:0]   sum;

   dvsd_8216m3 u_mul (
      .a (op_a_q),
      .b (op_b_q),
      .p (product)
   );

   always_comb begin
      in_acc      = in_valid & in_ready_q;
      out_acc     = out_valid_q & out_ready;
      sum         = {1'b0, acc_q} + (ACC_W + 1)'(product);
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_last_d   = op_last_q;
      op_v_d      = in_acc;
      acc_d       = acc_q;
      ovf_d       = ovf_q;

      if (in_acc) begin
         op_a_d    = a;
         op_b_d    = b;
         op_last_d = (cnt_q == CNT_LAST);
         cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end

      // The carry out of the widened add is the overflow flag in both builds.
      if (op_v_q) begin
         if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef DVSD_MAC_SAT_EN
         acc_d = (sum[ACC_W] || ovf_q) ? ACC_MAX : sum[ACC_W-1:0];
`else
         acc_d = sum[ACC_W-1:0];
`endif
      end

      case (state_q)
         ST_ACCUM: if (in_acc && cnt_q == CNT_LAST) state_d = ST_FLUSH;
         ST_FLUSH: if (op_v_q && op_last_q) state_d = ST_OUT;
         ST_OUT: begin
            if (out_acc) begin
               state_d = ST_ACCUM;
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      in_ready_d  = (state_d == ST_ACCUM);
      out_valid_d = (state_d == ST_OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_v_q      <= 1'b0;
         op_last_q   <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_v_q      <= op_v_d;
         op_last_q   <= op_last_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_dvsd_mul_acc.sv
// Directed bench for dvsd_mul_acc: a 24-bit instance and a 17-bit overflow instance share stimulus.

module tb_dvsd_mul_acc;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic [7:0]  aIn;
   logic [7:0]  bIn;
   logic        outReady;
   logic        inReady, inReady17;
   logic        outValid, outValid17;
   logic [23:0] outData;
   logic [16:0] outData17;
   logic        ovfOut, ovfOut17;
   int          checkCount;
   int          passCount;

   dvsd_mul_acc #(.LEN(4), .ACC_W(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .a         (aIn),
      .b         (bIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .ovf       (ovfOut)
   );

   dvsd_mul_acc #(.LEN(4), .ACC_W(17)) dut17 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady17),
      .a         (aIn),
      .b         (bIn),
      .out_valid (outValid17),
      .out_ready (outReady),
      .out_data  (outData17),
      .ovf       (ovfOut17)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checkCount++;
      if (got === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
   endtask

   // Offer one pair and return 1 ns after the edge that accepts it
   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input int gap);
      int waited;
      waited = 0;
      aIn = x;
      bIn = y;
      inValid = 1'b1;
      while (!inReady && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!inReady) checkOutput("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Called 1 ns after the last accept; checks latency, value and one-cycle valid with outReady high
   task automatic expectResult(input string tag, input logic [31:0] expData, input logic expOvf);
      checkOutput({tag, "_flush_valid"}, 32'(outValid), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_data"}, 32'(outData), expData);
      checkOutput({tag, "_ovf"}, 32'(ovfOut), 32'(expOvf));
      checkOutput({tag, "_ready_low"}, 32'(inReady), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_valid_drop"}, 32'(outValid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(inReady), 32'd1);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst      = 1'b1;
      inValid  = 1'b0;
      aIn      = '0;
      bIn      = '0;
      outReady = 1'b1;
      #12;
      checkOutput("rst_in_ready", 32'(inReady), 32'd0);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_out_data", 32'(outData), 32'd0);
      checkOutput("rst_ovf", 32'(ovfOut), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready_after_rst", 32'(inReady), 32'd1);

      $display("[TB] basic result");
      applyStimulus(8'd3, 8'd5, 0);
      applyStimulus(8'd10, 8'd20, 0);
      applyStimulus(8'd255, 8'd255, 0);
      applyStimulus(8'd0, 8'd77, 0);
      expectResult("basic", 32'd65240, 1'b0);

      $display("[TB] backpressure");
      outReady = 1'b0;
      applyStimulus(8'd3, 8'd5, 0);
      applyStimulus(8'd10, 8'd20, 0);
      applyStimulus(8'd255, 8'd255, 0);
      applyStimulus(8'd0, 8'd77, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", 32'(outValid), 32'd1);
         checkOutput("bp_data", 32'(outData), 32'd65240);
         checkOutput("bp_ready", 32'(inReady), 32'd0);
         @(posedge clk); #1;
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_valid_drop", 32'(outValid), 32'd0);
      checkOutput("bp_ready_back", 32'(inReady), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(8'd1, 8'd1, 0);
      expectResult("second", 32'd4, 1'b0);

      $display("[TB] bubbles");
      applyStimulus(8'd3, 8'd5, 3);
      applyStimulus(8'd10, 8'd20, 3);
      applyStimulus(8'd255, 8'd255, 3);
      applyStimulus(8'd0, 8'd77, 0);
      expectResult("bubble", 32'd65240, 1'b0);

      $display("[TB] overflow");
      for (int i = 0; i < 4; i++) applyStimulus(8'd255, 8'd255, 0);
      @(posedge clk); #1;
      checkOutput("ovf17_valid", 32'(outValid17), 32'd1);
      checkOutput("ovf17_flag", 32'(ovfOut17), 32'd1);
`ifdef DVSD_MAC_SAT_EN
      checkOutput("ovf17_data", 32'(outData17), 32'd131071);
`else
      checkOutput("ovf17_data", 32'(outData17), 32'd129028);
`endif
      checkOutput("ovf24_data", 32'(outData), 32'd260100);
      checkOutput("ovf24_flag", 32'(ovfOut), 32'd0);
      @(posedge clk); #1;
      checkOutput("ovf17_cleared", 32'(ovfOut17), 32'd0);

      $display("[TB] reset mid-result");
      applyStimulus(8'd200, 8'd200, 0);
      applyStimulus(8'd200, 8'd200, 0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_ready", 32'(inReady), 32'd0);
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) applyStimulus(8'd2, 8'd3, 0);
      expectResult("after_rst", 32'd24, 1'b0);

      $display("[TB] simultaneous output accept and input");
      for (int i = 0; i < 4; i++) applyStimulus(8'd1, 8'd1, 0);
      @(posedge clk); #1;
      checkOutput("sim_valid", 32'(outValid), 32'd1);
      checkOutput("sim_data", 32'(outData), 32'd4);
      aIn = 8'd7;
      bIn = 8'd7;
      inValid = 1'b1;
      @(posedge clk); #1;
      checkOutput("sim_valid_drop", 32'(outValid), 32'd0);
      checkOutput("sim_ready_back", 32'(inReady), 32'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(8'd1, 8'd1, 0);
      expectResult("sim_next", 32'd52, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
